da_mm_engine: RTL and testbench

DA_MM_ENGINE -- requirements
Module: da_mm_engine

---
 rtl/da_mm_pkg.sv | 39 +++
 rtl/da_mm_col.sv | 63 ++++++
 rtl/da_mm_engine.sv | 155 +++++++++++++++
 tb/tb_da_mm_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_mm_pkg.sv
// Shared types and helpers for the distributed-arithmetic matrix-multiply engine.
package da_mm_pkg;

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } rs_t;

  function automatic int unsigned acc_width(input int unsigned dwa, input int unsigned dwb,
                                            input int unsigned k);
    return dwa + dwb + $clog2(k) + 1;
  endfunction

  // Round half up by 'shift' bits, then clip to a signed 'ow'-bit range.
  function automatic rs_t round_sat(input logic signed [63:0] r, input int unsigned shift,
                                    input int unsigned ow);
    logic signed [63:0] rr;
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    rs_t                res;
    rr = r;
    if (shift > 0) rr = (r + (64'sd1 <<< (shift - 1))) >>> shift;
    maxv = (64'sd1 <<< (ow - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (ow - 1));
    res.sat = 1'b0;
    res.val = rr;
    if (rr > maxv) begin
      res.val = maxv;
      res.sat = 1'b1;
    end else if (rr < minv) begin
      res.val = minv;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/da_mm_col.sv
// One output column: masked B sum, bit-serial DA accumulator, round/saturate and result register.
module da_mm_col
  import da_mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_A = 8,
  parameter int unsigned DATA_WIDTH_B = 8,
  parameter int unsigned K            = 8,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned SHIFT        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          step_i,
  input  logic                          sign_i,
  input  logic [$clog2(DATA_WIDTH_A)-1:0] t_i,
  input  logic [K-1:0]                  a_bits_i,
  input  logic [K*DATA_WIDTH_B-1:0]     b_col_i,
  input  logic [OUT_WIDTH-1:0]          bias_i,
  output logic [OUT_WIDTH-1:0]          final_o,
  output logic                          sat_o
);

  localparam int unsigned AccW = acc_width(DATA_WIDTH_A, DATA_WIDTH_B, K);
  localparam int unsigned PW   = DATA_WIDTH_B + $clog2(K) + 1;

  logic signed [PW-1:0]   psum;
  logic signed [AccW-1:0] p_sh, acc_sum, acc_d, acc_q;
  logic [OUT_WIDTH-1:0]   out_q;
  logic                   sat_q;
  rs_t                    res;

  always_comb begin
    psum = '0;
    for (int k = 0; k < K; k++) begin
      if (a_bits_i[k]) psum = psum + PW'($signed(b_col_i[k*DATA_WIDTH_B +: DATA_WIDTH_B]));
    end
  end

  // The sign bit of A carries negative weight in two's complement.
  assign p_sh    = AccW'(psum) <<< t_i;
  assign acc_sum = sign_i ? (acc_q - p_sh) : (acc_q + p_sh);
  assign acc_d   = clear_i ? '0 : (step_i ? acc_sum : acc_q);
  assign res     = round_sat(64'(acc_sum) + 64'($signed(bias_i)), SHIFT, OUT_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (step_i && sign_i) begin
        out_q <= res.val[OUT_WIDTH-1:0];
        sat_q <= res.sat;
      end
    end
  end

  assign final_o = out_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/da_mm_engine.sv
// Bit-serial distributed-arithmetic M x K by K x N matrix multiply with per-row output handshake.
// Optional bias addition is enabled by defining DA_MM_BIAS_EN.
module da_mm_engine
  import da_mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_A = 8,
  parameter int unsigned DATA_WIDTH_B = 8,
  parameter int unsigned M            = 2,
  parameter int unsigned K            = 8,
  parameter int unsigned N            = 4,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned SHIFT        = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_valid_i,
  output logic                               start_ready_o,
  input  logic [M*K*DATA_WIDTH_A-1:0]        a_i,
  input  logic [K*N*DATA_WIDTH_B-1:0]        b_i,
  input  logic [N*OUT_WIDTH-1:0]             bias_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row_o,
  output logic [N*OUT_WIDTH-1:0]             final_out_o,
  output logic [N-1:0]                       sat_flag_o,
  output logic                               busy_o
);

  localparam int unsigned RowW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned TW   = $clog2(DATA_WIDTH_A);

  state_e                  state_q, state_d;
  logic [RowW-1:0]         m_q, m_d;
  logic [TW-1:0]           t_q, t_d;
  logic                    capture, clear, step, last_t;
  logic [DATA_WIDTH_A-1:0] a_q [M][K];
  logic [DATA_WIDTH_B-1:0] b_q [K][N];
  logic [K-1:0]            a_bits;

  assign capture = (state_q == StIdle) && start_valid_i;
  assign last_t  = (t_q == TW'(DATA_WIDTH_A - 1));
  assign step    = (state_q == StCompute);

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int m = 0; m < M; m++) begin
        for (int k = 0; k < K; k++) a_q[m][k] <= a_i[(m*K+k)*DATA_WIDTH_A +: DATA_WIDTH_A];
      end
      for (int k = 0; k < K; k++) begin
        for (int n = 0; n < N; n++) b_q[k][n] <= b_i[(k*N+n)*DATA_WIDTH_B +: DATA_WIDTH_B];
      end
    end
  end

`ifdef DA_MM_BIAS_EN
  logic [OUT_WIDTH-1:0] bias_q [N];
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int n = 0; n < N; n++) bias_q[n] <= bias_i[n*OUT_WIDTH +: OUT_WIDTH];
    end
  end
`else
  logic unused_bias;
  assign unused_bias = ^bias_i;
`endif

  always_comb begin
    for (int k = 0; k < K; k++) a_bits[k] = a_q[m_q][k][t_q];
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    t_d     = t_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_valid_i) begin
          state_d = StCompute;
          m_d     = '0;
          t_d     = '0;
          clear   = 1'b1;
        end
      end
      StCompute: begin
        if (last_t) state_d = StOutput;
        else        t_d     = t_q + TW'(1);
      end
      StOutput: begin
        if (out_ready_i) begin
          t_d   = '0;
          clear = 1'b1;
          if (m_q == RowW'(M - 1)) begin
            state_d = StIdle;
            m_d     = '0;
          end else begin
            state_d = StCompute;
            m_d     = m_q + RowW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      t_q     <= t_d;
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_col
    logic [K*DATA_WIDTH_B-1:0] b_col;
    logic [OUT_WIDTH-1:0]      col_bias;
    for (genvar k = 0; k < K; k++) begin : g_b
      assign b_col[k*DATA_WIDTH_B +: DATA_WIDTH_B] = b_q[k][n];
    end
`ifdef DA_MM_BIAS_EN
    assign col_bias = bias_q[n];
`else
    assign col_bias = '0;
`endif
    da_mm_col #(
      .DATA_WIDTH_A (DATA_WIDTH_A),
      .DATA_WIDTH_B (DATA_WIDTH_B),
      .K            (K),
      .OUT_WIDTH    (OUT_WIDTH),
      .SHIFT        (SHIFT)
    ) u_col (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear),
      .step_i   (step),
      .sign_i   (last_t),
      .t_i      (t_q),
      .a_bits_i (a_bits),
      .b_col_i  (b_col),
      .bias_i   (col_bias),
      .final_o  (final_out_o[n*OUT_WIDTH +: OUT_WIDTH]),
      .sat_o    (sat_flag_o[n])
    );
  end

  assign start_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign out_valid_o   = (state_q == StOutput);
  assign out_row_o     = m_q;

endmodule

// File: tb/tb_da_mm_engine.sv
// Self-checking bench: randomized jobs against a plain-arithmetic matrix model, two SHIFT settings.
module tb_da_mm_engine;

  localparam int DWA = 8;
  localparam int DWB = 8;
  localparam int M   = 2;
  localparam int K   = 8;
  localparam int N   = 4;
  localparam int OW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [M*K*DWA-1:0] a_i = '0;
  logic [K*N*DWB-1:0] b_i = '0;
  logic [N*OW-1:0]    bias_i = '0;

  logic          start_ready0, out_valid0, busy0, start_ready2, out_valid2, busy2;
  logic [0:0]    out_row0, out_row2;
  logic [N*OW-1:0] final_out0, final_out2;
  logic [N-1:0]  sat0, sat2;

  always #5 clk = ~clk;

  da_mm_engine #(.DATA_WIDTH_A(DWA), .DATA_WIDTH_B(DWB), .M(M), .K(K), .N(N), .OUT_WIDTH(OW),
                 .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start_valid_i(start_valid), .start_ready_o(start_ready0),
    .a_i(a_i), .b_i(b_i), .bias_i(bias_i), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_row_o(out_row0), .final_out_o(final_out0), .sat_flag_o(sat0), .busy_o(busy0));

  da_mm_engine #(.DATA_WIDTH_A(DWA), .DATA_WIDTH_B(DWB), .M(M), .K(K), .N(N), .OUT_WIDTH(OW),
                 .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid_i(start_valid), .start_ready_o(start_ready2),
    .a_i(a_i), .b_i(b_i), .bias_i(bias_i), .out_valid_o(out_valid2), .out_ready_i(out_ready),
    .out_row_o(out_row2), .final_out_o(final_out2), .sat_flag_o(sat2), .busy_o(busy2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: whole-job matrix product computed at capture, plus a transaction timeline.
  longint e0 [M][N];
  longint e2 [M][N];
  bit     s0 [M][N];
  bit     s2 [M][N];
  bit     mb = 0, mv = 0;
  int     mr = 0, mc = 0;

  function automatic longint rsat(input longint r, input int sh, output bit sat);
    longint v, hi, lo;
    v = r;
    if (sh > 0) v = (r + (longint'(1) << (sh - 1))) >>> sh;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    sat = 0;
    if (v > hi) begin v = hi; sat = 1; end
    else if (v < lo) begin v = lo; sat = 1; end
    return v;
  endfunction

  task automatic model_capture();
    longint acc;
    bit st;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        acc = 0;
        for (int k = 0; k < K; k++)
          acc += longint'($signed(a_i[(m*K+k)*DWA +: DWA])) *
                 longint'($signed(b_i[(k*N+n)*DWB +: DWB]));
`ifdef DA_MM_BIAS_EN
        acc += longint'($signed(bias_i[n*OW +: OW]));
`endif
        e0[m][n] = rsat(acc, 0, st); s0[m][n] = st;
        e2[m][n] = rsat(acc, 2, st); s2[m][n] = st;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb = 0; mv = 0; mr = 0; mc = 0;
    end else if (!mb) begin
      if (start_valid) begin
        model_capture();
        mb = 1; mv = 0; mr = 0; mc = DWA;
      end
    end else if (!mv) begin
      mc--;
      if (mc == 0) mv = 1;
    end else if (out_ready) begin
      if (mr == M - 1) begin mb = 0; mv = 0; end
      else begin mr++; mv = 0; mc = DWA; end
    end
  end

  always @(negedge clk) begin
    chk("start_ready", longint'(start_ready0), longint'(!mb));
    chk("busy", longint'(busy0), longint'(mb));
    chk("out_valid", longint'(out_valid0), longint'(mv));
    chk("out_valid_s2", longint'(out_valid2), longint'(mv));
    chk("busy_s2", longint'(busy2), longint'(mb));
    if (mv) begin
      chk("out_row", longint'(out_row0), longint'(mr));
      chk("out_row_s2", longint'(out_row2), longint'(mr));
      for (int n = 0; n < N; n++) begin
        chk($sformatf("final_out[%0d]", n), longint'($signed(final_out0[n*OW +: OW])), e0[mr][n]);
        chk($sformatf("sat_flag[%0d]", n), longint'(sat0[n]), longint'(s0[mr][n]));
        chk($sformatf("final_out_s2[%0d]", n), longint'($signed(final_out2[n*OW +: OW])),
            e2[mr][n]);
        chk($sformatf("sat_flag_s2[%0d]", n), longint'(sat2[n]), longint'(s2[mr][n]));
      end
    end
  end

  int ta [M][K];
  int tb [K][N];
  int tbias [N];

  task automatic drive_ops();
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) a_i[(m*K+k)*DWA +: DWA] = DWA'(ta[m][k]);
    for (int k = 0; k < K; k++)
      for (int n = 0; n < N; n++) b_i[(k*N+n)*DWB +: DWB] = DWB'(tb[k][n]);
    for (int n = 0; n < N; n++) bias_i[n*OW +: OW] = OW'(tbias[n]);
  endtask

  task automatic scramble();
    for (int i = 0; i < M*K; i++) a_i[i*DWA +: DWA] = DWA'($urandom);
    for (int i = 0; i < K*N; i++) b_i[i*DWB +: DWB] = DWB'($urandom);
    for (int i = 0; i < N; i++) bias_i[i*OW +: OW] = OW'($urandom);
  endtask

  task automatic fill(input int av, input int bv, input int bias_step);
    for (int m = 0; m < M; m++) for (int k = 0; k < K; k++) ta[m][k] = av;
    for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) tb[k][n] = bv;
    for (int n = 0; n < N; n++) tbias[n] = bias_step * n;
  endtask

  task automatic fill_random();
    int ext;
    ext = $urandom_range(0, 3);
    for (int m = 0; m < M; m++) for (int k = 0; k < K; k++)
      ta[m][k] = (ext == 0) ? ($urandom_range(0, 1) ? 127 : -128) : $urandom_range(0, 255) - 128;
    for (int k = 0; k < K; k++) for (int n = 0; n < N; n++)
      tb[k][n] = (ext == 0) ? ($urandom_range(0, 1) ? 127 : -128) : $urandom_range(0, 255) - 128;
    for (int n = 0; n < N; n++) tbias[n] = $urandom_range(0, 4000) - 2000;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready held low 5 cycles per row
  task automatic run_job(input int mode);
    int rows, guard, hold, lat;
    bit seen;
    drive_ops();
    start_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    start_valid = 0;
    rows = 0; guard = 0; hold = 0; lat = 0; seen = 0;
    while (rows < M && guard < 200) begin
      if (!seen && out_valid0) begin
        seen = 1;
        chk("latency", lat, DWA);
      end
      scramble();
      start_valid = $urandom_range(0, 1);
      if (mode == 0) out_ready = 1;
      else if (mode == 1) out_ready = $urandom_range(0, 1);
      else if (mv) begin out_ready = (hold >= 5); hold++; end
      else begin out_ready = 0; hold = 0; end
      if (mv && out_ready) rows++;
      @(posedge clk); #1;
      guard++; lat++;
    end
    start_valid = 0; out_ready = 0;
    chk("rows_completed", rows, M);
    chk("valid_seen", longint'(seen), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", longint'(start_ready0), 1);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_out_row", longint'(out_row0), 0);
    chk("rst_final_out", longint'(final_out0 != '0), 0);
    chk("rst_sat_flag", longint'(sat0), 0);
    rst = 0;
    @(posedge clk); #1;

    fill(1, 1, 0);
    run_job(0);
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) chk("pin_ones", e0[m][n], 8);

    fill(-128, -128, 0);
    run_job(1);
    chk("pin_sat_pos", e0[0][0], 32767);
    chk("pin_sat_pos_flag", longint'(s0[1][3]), 1);

    fill(-128, 127, 0);
    run_job(0);
    chk("pin_sat_neg", e0[1][2], -32768);
    chk("pin_sat_neg_flag", longint'(s0[0][1]), 1);

    fill(0, 55, 10);
    run_job(1);
    for (int n = 0; n < N; n++) begin
`ifdef DA_MM_BIAS_EN
      chk("pin_bias", e0[0][n], 10 * n);
`else
      chk("pin_bias", e0[0][n], 0);
`endif
    end

    fill(0, 0, 0);
    ta[0][0] = 1; ta[1][0] = -1;
    tb[0][0] = 6; tb[0][1] = 5; tb[0][2] = 6; tb[0][3] = 5;
    run_job(0);
    chk("pin_shift_6", e2[0][0], 2);
    chk("pin_shift_5", e2[0][1], 1);
    chk("pin_shift_m6", e2[1][0], -1);

    fill_random();
    run_job(2);

    // Reset in the middle of row 0.
    fill_random();
    drive_ops();
    start_valid = 1;
    @(posedge clk); #1;
    start_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("abort_out_valid", longint'(out_valid0), 0);
    chk("abort_busy", longint'(busy0), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("abort_start_ready", longint'(start_ready0), 1);
    fill_random();
    run_job(0);

    for (int j = 0; j < 25; j++) begin
      fill_random();
      run_job($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
